// File: rtl/adc_sar_control_pkg.sv
// Shared constants and state encoding for the SAR ADC conversion controller.
package adc_sar_control_pkg;

  localparam int ADC_W       = 10;
  localparam int ACC_W       = 13;
  localparam int OSR_MAX_EXP = 3;
  localparam int OSR_W       = $clog2(OSR_MAX_EXP + 1);
  localparam int CONV_CYCLES = 2 * ADC_W;

  localparam logic [ADC_W-1:0] ADC_MSB = ADC_W'(1) << (ADC_W - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAMPLE  = 2'd1,
    S_CONVERT = 2'd2,
    S_DONE    = 2'd3
  } sar_state_t;

  function automatic logic [3:0] osr_iterations(input logic [OSR_W-1:0] osr);
    return 4'(1) << osr;
  endfunction

endpackage

// File: rtl/adc_sar_osr_accumulator.sv
// Next-value logic for the oversampling accumulator: clear, add a word, and the averaged shift-out.
module adc_sar_osr_accumulator
  import adc_sar_control_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [ADC_W-1:0] word,
  input  logic             clear,
  input  logic             add,
  input  logic [OSR_W-1:0] osr,
  output logic [ACC_W-1:0] acc_next,
  output logic [ADC_W-1:0] avg
);

  always_comb begin
    acc_next = acc;
    if (clear) begin
      acc_next = '0;
    end else if (add) begin
      acc_next = acc + ACC_W'(word);
    end
  end

  // 2^3 full-scale words fit in 13 bits, so the shifted sum always fits the result width.
  assign avg = ADC_W'(acc_next >> osr);

endmodule

// File: rtl/adc_sar_control.sv
// SAR ADC conversion sequencer: sample, 10-bit successive approximation, optional averaging.
module adc_sar_control
  import adc_sar_control_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_conversion_in,
  input  logic             comparator_in,
  input  logic [3:0]       config_sample_cycles_in,
  input  logic [OSR_W-1:0] config_osr_in,
  output logic             sample_out,
  output logic [ADC_W-1:0] data_to_dac_out,
  output logic             conversion_busy_out,
  output logic             conversion_finished_out,
  output logic [ADC_W-1:0] result_out
);

  sar_state_t       state, state_next;
  logic [3:0]       sample_cfg;
  logic [OSR_W-1:0] osr_cfg;
  logic [4:0]       cnt;
  logic [3:0]       iter;
  logic [ADC_W-1:0] trial, trial_decided, bit_mask;
  logic [3:0]       bit_idx;
  logic [ACC_W-1:0] acc, acc_next;
  logic [ADC_W-1:0] avg, result;
  logic             load_cfg, acc_clear, acc_add, result_load;
  logic             sample_end, convert_end;

  assign sample_end    = ({1'b0, sample_cfg} == cnt);
  assign convert_end   = (cnt == 5'(CONV_CYCLES - 1));
  // Two cycles per bit: cnt[4:1] walks the bit index from MSB downward, cnt[0] marks DECIDE.
  assign bit_idx       = 4'(ADC_W - 1) - cnt[4:1];
  assign bit_mask      = ADC_W'(1) << bit_idx;
  assign trial_decided = comparator_in ? trial : (trial & ~bit_mask);
  assign result_out    = result;

  adc_sar_osr_accumulator u_acc (
    .acc      (acc),
    .word     (trial_decided),
    .clear    (acc_clear),
    .add      (acc_add),
    .osr      (osr_cfg),
    .acc_next (acc_next),
    .avg      (avg)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next              = state;
    sample_out              = 1'b0;
    data_to_dac_out         = '0;
    conversion_busy_out     = 1'b1;
    conversion_finished_out = 1'b0;
    load_cfg                = 1'b0;
    acc_clear               = 1'b0;
    acc_add                 = 1'b0;
    result_load             = 1'b0;
    unique case (state)
      S_IDLE: begin
        conversion_busy_out = 1'b0;
        if (start_conversion_in) begin
          state_next = S_SAMPLE;
          load_cfg   = 1'b1;
          acc_clear  = 1'b1;
        end
      end
      S_SAMPLE: begin
        sample_out = 1'b1;
        if (sample_end) begin
          state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        data_to_dac_out = trial;
        if (convert_end) begin
          acc_add = 1'b1;
          if (iter + 4'd1 < osr_iterations(osr_cfg)) begin
            state_next = S_SAMPLE;
          end else begin
            state_next  = S_DONE;
            result_load = 1'b1;
          end
        end
      end
      S_DONE: begin
        conversion_finished_out = 1'b1;
        state_next              = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sample_cfg <= '0;
      osr_cfg    <= '0;
      cnt        <= '0;
      iter       <= '0;
      trial      <= '0;
      acc        <= '0;
      result     <= '0;
    end else begin
      acc <= acc_next;
      if (load_cfg) begin
        sample_cfg <= config_sample_cycles_in;
        osr_cfg    <= config_osr_in;
      end
      // Loaded on the edge into DONE so the new value is visible during the finished pulse.
      if (result_load) begin
        result <= avg;
      end
      unique case (state)
        S_IDLE: begin
          cnt   <= '0;
          iter  <= '0;
          trial <= '0;
        end
        S_SAMPLE: begin
          if (sample_end) begin
            cnt   <= '0;
            trial <= ADC_MSB;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_CONVERT: begin
          if (convert_end) begin
            cnt   <= '0;
            iter  <= iter + 4'd1;
            trial <= '0;
          end else begin
            cnt <= cnt + 5'd1;
            if (cnt[0]) begin
              trial <= trial_decided | (bit_mask >> 1);
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sar_control.sv
// Directed and randomized bench for adc_sar_control with an ideal-comparator input model.
module tb_adc_sar_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_conversion_in = 1'b0;
  logic       comparator_in;
  logic [3:0] config_sample_cycles_in = 4'd0;
  logic [1:0] config_osr_in = 2'd0;
  logic       sample_out;
  logic [9:0] data_to_dac_out;
  logic       conversion_busy_out;
  logic       conversion_finished_out;
  logic [9:0] result_out;

  int total = 0;
  int bad = 0;
  int vin_arr[16];
  int sample_phases = 0;
  int base_phases = 0;
  int cmp_idx;
  logic prev_sample = 1'b0;
  int trial_q[$];

  adc_sar_control dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .start_conversion_in     (start_conversion_in),
    .comparator_in           (comparator_in),
    .config_sample_cycles_in (config_sample_cycles_in),
    .config_osr_in           (config_osr_in),
    .sample_out              (sample_out),
    .data_to_dac_out         (data_to_dac_out),
    .conversion_busy_out     (conversion_busy_out),
    .conversion_finished_out (conversion_finished_out),
    .result_out              (result_out)
  );

  always #5 clk = ~clk;

  // Each SAMPLE phase selects the next analog input voltage from vin_arr.
  always @(negedge clk) begin
    if (sample_out && !prev_sample) sample_phases <= sample_phases + 1;
    prev_sample <= sample_out;
  end

  always_comb begin
    cmp_idx = sample_phases - base_phases - 1;
    if (cmp_idx < 0) cmp_idx = 0;
    else if (cmp_idx > 15) cmp_idx = 15;
    comparator_in = (vin_arr[cmp_idx[3:0]] >= int'(data_to_dac_out));
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_conv(input int n_val, input int osr, input bit disturb, input string tag);
    int n, iters, exp_lat, exp_res, sum, lat, samp, ph0;
    n = n_val + 1;
    iters = 1 << osr;
    exp_lat = iters * (n + 20) + 1;
    sum = 0;
    for (int i = 0; i < iters; i++) sum += vin_arr[i];
    exp_res = sum >> osr;
    @(negedge clk);
    config_sample_cycles_in = 4'(n_val);
    config_osr_in = 2'(osr);
    start_conversion_in = 1'b1;
    base_phases = sample_phases;
    ph0 = sample_phases;
    trial_q.delete();
    lat = -1;
    samp = 0;
    for (int k = 1; k <= exp_lat + 8; k++) begin
      @(negedge clk);
      if (k == 1) start_conversion_in = 1'b0;
      if (disturb && k == n + 8) begin
        start_conversion_in = 1'b1;
        config_sample_cycles_in = 4'(n_val) ^ 4'hF;
        config_osr_in = 2'(osr) ^ 2'b11;
      end
      if (disturb && k == n + 9) begin
        start_conversion_in = 1'b0;
        config_sample_cycles_in = 4'(n_val);
        config_osr_in = 2'(osr);
      end
      if (sample_out) samp++;
      if (data_to_dac_out != 10'd0 && trial_q.size() < 20) trial_q.push_back(int'(data_to_dac_out));
      if (conversion_finished_out) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_result"}, int'(result_out), exp_res);
    chk({tag, "_dac_in_done"}, int'(data_to_dac_out), 0);
    chk({tag, "_sample_in_done"}, int'(sample_out), 0);
    chk({tag, "_sample_cycles"}, samp, iters * n);
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, int'(conversion_finished_out), 0);
    chk({tag, "_idle_busy"}, int'(conversion_busy_out), 0);
    chk({tag, "_result_held"}, int'(result_out), exp_res);
    chk({tag, "_sample_phases"}, sample_phases - ph0, iters);
  endtask

  initial begin
    int w, t, fins, fin1, fin2, res1, res2;
    for (int i = 0; i < 16; i++) vin_arr[i] = 0;

    // Reset dominates a held start request.
    rst_n = 1'b0;
    start_conversion_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(conversion_busy_out), 0);
    chk("rst_dac", int'(data_to_dac_out), 0);
    chk("rst_sample", int'(sample_out), 0);
    chk("rst_finished", int'(conversion_finished_out), 0);
    chk("rst_result", int'(result_out), 0);
    start_conversion_in = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_rst", int'(conversion_busy_out), 0);

    // Vin = 613, N=1, no oversampling; SET-cycle words follow a binary search.
    vin_arr[0] = 613;
    run_conv(0, 0, 1'b0, "v613");
    w = 0;
    for (int b = 9; b >= 0; b--) begin
      t = w | (1 << b);
      chk($sformatf("v613_trial_bit%0d", b), (trial_q.size() > 2 * (9 - b)) ? trial_q[2 * (9 - b)] : -1, t);
      if (613 >= t) w = t;
    end

    vin_arr[0] = 0;
    run_conv(0, 0, 1'b0, "vmin");
    vin_arr[0] = 1023;
    run_conv(0, 0, 1'b0, "vmax");

    for (int i = 0; i < 4; i++) vin_arr[i] = 100 + i;
    run_conv(3, 2, 1'b0, "osr2");

    vin_arr[0] = 613;
    vin_arr[1] = 400;
    run_conv(2, 1, 1'b1, "disturb");

    // Reset asserted on the SET cycle of bit 5 aborts the conversion.
    vin_arr[0] = 500;
    @(negedge clk);
    config_sample_cycles_in = 4'd1;
    config_osr_in = 2'd0;
    start_conversion_in = 1'b1;
    base_phases = sample_phases;
    for (int k = 1; k <= 2 + 9; k++) begin
      @(negedge clk);
      if (k == 1) start_conversion_in = 1'b0;
    end
    chk("midrst_busy_before", int'(conversion_busy_out), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", int'(conversion_busy_out), 0);
    chk("midrst_dac", int'(data_to_dac_out), 0);
    chk("midrst_sample", int'(sample_out), 0);
    chk("midrst_finished", int'(conversion_finished_out), 0);
    chk("midrst_result", int'(result_out), 0);
    fins = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (conversion_finished_out || conversion_busy_out) fins++;
    end
    chk("midrst_no_activity", fins, 0);
    vin_arr[0] = 777;
    run_conv(0, 0, 1'b0, "after_rst");

    // Start held high: second conversion accepted in the IDLE cycle after DONE.
    vin_arr[0] = 300;
    vin_arr[1] = 700;
    @(negedge clk);
    config_sample_cycles_in = 4'd2;
    config_osr_in = 2'd0;
    start_conversion_in = 1'b1;
    base_phases = sample_phases;
    fin1 = -1;
    fin2 = -1;
    res1 = -1;
    res2 = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (fin1 > 0 && k == fin1 + 2) start_conversion_in = 1'b0;
      if (conversion_finished_out) begin
        if (fin1 < 0) begin
          fin1 = k;
          res1 = int'(result_out);
        end else begin
          fin2 = k;
          res2 = int'(result_out);
          break;
        end
      end
    end
    start_conversion_in = 1'b0;
    chk("b2b_fin1", fin1, 24);
    chk("b2b_res1", res1, 300);
    chk("b2b_fin2", fin2, 49);
    chk("b2b_res2", res2, 700);
    repeat (2) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      int n_val, osr;
      n_val = int'($urandom_range(0, 15));
      osr = int'($urandom_range(0, 3));
      for (int i = 0; i < 8; i++) vin_arr[i] = int'($urandom_range(0, 1023));
      run_conv(n_val, osr, 1'b0, $sformatf("rand%0d", r));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_sar_control.md
ADC_SAR_CONTROL -- requirements
Module: adc_sar_control

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  block clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 start_conversion_in  input  1  request a conversion; sampled only in IDLE.
REQ-005 comparator_in  input  1  comparator decision, 1 = Vin >= Vdac.
REQ-006 config_sample_cycles_in  input  4  sample phase length N = value+1 cycles.
REQ-007 config_osr_in  input  2  oversampling; 2^value conversions averaged per result.
REQ-008 sample_out  input-side control, output  1  high during SAMPLE state only.
REQ-009 data_to_dac_out  output  10  trial word driving the adc_row_col_decoder data_in.
REQ-010 conversion_busy_out  output  1  high in every state except IDLE.
REQ-011 conversion_finished_out  output  1  one-cycle pulse when result_out updates.
REQ-012 result_out  output  10  last averaged result; held until next update.

Function
REQ-013 The FSM SHALL have states IDLE, SAMPLE, CONVERT, DONE.
REQ-014 IDLE with start_conversion_in=1 SHALL latch both config inputs, clear accumulator and iteration counter, and go to SAMPLE next cycle.
REQ-015 SAMPLE SHALL last exactly N cycles with data_to_dac_out=0 and sample_out=1, then go to CONVERT.
REQ-016 CONVERT SHALL resolve bits 9 down to 0, two cycles per bit: SET cycle drives current bit to 1 on data_to_dac_out; DECIDE cycle samples comparator_in, keeping the bit if 1, clearing it if 0.
REQ-017 The first CONVERT cycle SHALL present 10'b10_0000_0000; CONVERT SHALL last exactly 20 cycles.
REQ-018 After bit 0 DECIDE, the final word SHALL be added to a 13-bit accumulator; if iterations < 2^osr go to SAMPLE, else go to DONE.
REQ-019 DONE SHALL last one cycle: result_out = accumulator >> osr (truncating), conversion_finished_out=1, then IDLE.
REQ-020 Latency from start-accepting cycle (cycle 0) to finished pulse SHALL be 2^osr*(N+20)+1 cycles.
REQ-021 start_conversion_in outside IDLE SHALL be ignored; config changes outside IDLE SHALL have no effect on the running conversion.
REQ-022 In IDLE and DONE data_to_dac_out SHALL be 0; sample_out SHALL be 0.
REQ-023 start_conversion_in held high continuously SHALL start a new conversion in the cycle after DONE (back-to-back).

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE and zero data_to_dac_out, result_out, accumulator, counters, and all control outputs, in any state.
REQ-025 Reset mid-conversion SHALL abort without a finished pulse and without updating result_out beyond clearing it.

Structure
REQ-026 A shared package SHALL hold the state encoding, ADC resolution (10), accumulator width (13), and max OSR exponent (3).
REQ-027 The bit-trial register and accumulator SHALL stay in adc_sar_control; one sub-module, adc_sar_osr_accumulator (accumulate, clear, shift-out), is permitted.

Verification
REQ-028 Comparator model comp = (613 >= data_to_dac_out), N=1, osr=0, start -> trial sequence 512,768(drop),640(drop),576,...; result_out=613; finished pulse at cycle 22.
REQ-029 Vin model 0 and 1023 -> result_out=0 and 1023 respectively; every bit dropped / kept.
REQ-030 osr=2, N=4, Vin 100,101,102,103 per iteration -> result_out=101 at cycle 97; four SAMPLE phases observed.
REQ-031 start pulsed at CONVERT cycle 7 and config changed -> ignored; result and latency unchanged.
REQ-032 rst_n=0 at CONVERT bit 5 -> next cycle IDLE, all outputs 0, no finished pulse; new start then converts normally.
